// File: rtl/uart_tx_param.sv
// ============================================================================
// Module  : uart_tx_param
// Purpose : Parametrised UART transmitter with a valid/ready word interface and
//           an optional input FIFO, enabled by defining UART_TX_FIFO_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module uart_tx_param #(
  parameter int CLK_FREQ   = 125000000,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy
);

  localparam int BIT_TIME = CLK_FREQ / BAUD_RATE;
  localparam int CNT_W    = (BIT_TIME > 1) ? $clog2(BIT_TIME) : 1;
  localparam int IDX_W    = 4;
  localparam int BT_M1    = BIT_TIME - 1;
  localparam int DB_M1    = DATA_BITS - 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = BT_M1[CNT_W-1:0];
  localparam logic [IDX_W-1:0] IDX_LAST  = DB_M1[IDX_W-1:0];
  localparam logic             STOP_LAST = (STOP_BITS == 2);

  if (BIT_TIME < 2) begin : g_chk_bit_time
    $error("uart_tx_param: BIT_TIME must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_chk_data_bits
    $error("uart_tx_param: DATA_BITS must be 5..9");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_chk_stop_bits
    $error("uart_tx_param: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_chk_fifo_depth
    $error("uart_tx_param: FIFO_DEPTH must be a power of two >= 2");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   stop_q, stop_d;
  logic [DATA_BITS-1:0]   shreg_q, shreg_d;
  logic                   par_q, par_d;
  logic                   tx_q, tx_d;
  logic                   bit_end;
  logic                   take;
  logic [DATA_BITS-1:0]   word;

`ifdef UART_TX_FIFO_EN
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = FIFO_DEPTH[PTR_W:0];

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_q, wr_d, rd_q, rd_d;
  logic [PTR_W:0]       count_q, count_d;
  logic                 push, pop, full, empty;

  assign full     = (count_q == FULL_CNT);
  assign empty    = (count_q == '0);
  assign tx_ready = !full;
  assign push     = tx_valid && !full;
  assign pop      = (state_q == S_IDLE) && !empty;
  assign take     = pop;
  assign word     = mem_q[rd_q];
  assign tx_busy  = (state_q != S_IDLE) || !empty;

  always_comb begin
    wr_d    = push ? wr_q + 1'b1 : wr_q;
    rd_d    = pop  ? rd_q + 1'b1 : rd_q;
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: the pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= tx_data;
  end
`else
  assign tx_ready = (state_q == S_IDLE);
  assign take     = tx_valid && tx_ready;
  assign word     = tx_data;
  assign tx_busy  = (state_q != S_IDLE);
`endif

  assign bit_end = (cnt_q == CNT_MAX);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    stop_d  = stop_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    case (state_q)
      S_IDLE: begin
        if (take) begin
          state_d = S_START;
          cnt_d   = '0;
          idx_d   = '0;
          stop_d  = 1'b0;
          shreg_d = word;
          par_d   = (PARITY == 1) ? ~^word : ^word;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (idx_q == IDX_LAST) begin
            state_d = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            idx_d   = idx_q + 1'b1;
            shreg_d = shreg_q >> 1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          if (stop_q == STOP_LAST) state_d = S_IDLE;
          else                     stop_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Line level follows the next state so the start bit leaves one cycle after acceptance.
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shreg_d[0];
      S_PARITY: tx_d = par_d;
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      stop_q  <= 1'b0;
      shreg_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      stop_q  <= stop_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end

  assign tx = tx_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_param.sv
// ============================================================================
// Module  : tb_uart_tx_param
// Purpose : Directed self-checking bench for uart_tx_param at BIT_TIME = 10.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_uart_tx_param;

  localparam int CF = 1000000;
  localparam int BR = 100000;
  localparam int BT = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] d0, d1, d2;
  logic [6:0] d3;
  logic [3:0] vld, rdy, txs, bsy;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  uart_tx_param #(.CLK_FREQ(CF), .BAUD_RATE(BR), .FIFO_DEPTH(4)) u0 (
    .clk(clk), .rst(rst), .tx_data(d0), .tx_valid(vld[0]),
    .tx_ready(rdy[0]), .tx(txs[0]), .tx_busy(bsy[0]));
  uart_tx_param #(.CLK_FREQ(CF), .BAUD_RATE(BR), .PARITY(2)) u1 (
    .clk(clk), .rst(rst), .tx_data(d1), .tx_valid(vld[1]),
    .tx_ready(rdy[1]), .tx(txs[1]), .tx_busy(bsy[1]));
  uart_tx_param #(.CLK_FREQ(CF), .BAUD_RATE(BR), .PARITY(1)) u2 (
    .clk(clk), .rst(rst), .tx_data(d2), .tx_valid(vld[2]),
    .tx_ready(rdy[2]), .tx(txs[2]), .tx_busy(bsy[2]));
  uart_tx_param #(.CLK_FREQ(CF), .BAUD_RATE(BR), .DATA_BITS(7), .STOP_BITS(2)) u3 (
    .clk(clk), .rst(rst), .tx_data(d3), .tx_valid(vld[3]),
    .tx_ready(rdy[3]), .tx(txs[3]), .tx_busy(bsy[3]));

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chkn(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // f holds the frame LSB-first: bit 0 is the start bit.
  task automatic check_frame(input int k, input logic [15:0] f, input int ncyc, input logic chk_rdy);
    for (int c = 0; c < ncyc; c++) begin
      chk1($sformatf("tx u%0d cyc%0d", k, c), txs[k], f[c / BT]);
      chk1($sformatf("busy u%0d cyc%0d", k, c), bsy[k], 1'b1);
      if (chk_rdy) chk1($sformatf("ready u%0d cyc%0d", k, c), rdy[k], 1'b0);
      tick();
    end
  endtask

  task automatic check_idle(input int k, input string tag);
    chk1({tag, " tx"}, txs[k], 1'b1);
    chk1({tag, " busy"}, bsy[k], 1'b0);
    chk1({tag, " ready"}, rdy[k], 1'b1);
  endtask

`ifndef UART_TX_FIFO_EN
  task automatic send(input int k, input logic [7:0] d);
    case (k)
      0:       d0 = d;
      1:       d1 = d;
      2:       d2 = d;
      default: d3 = d[6:0];
    endcase
    vld[k] = 1'b1;
    chk1($sformatf("send ready u%0d", k), rdy[k], 1'b1);
    tick();
    vld[k] = 1'b0;
  endtask
`endif

  initial begin
    vld = '0;
    d0 = '0; d1 = '0; d2 = '0; d3 = '0;
    rst = 1'b1;
    tick();
    tick();
    for (int k = 0; k < 4; k++) begin
      chk1($sformatf("reset tx u%0d", k), txs[k], 1'b1);
      chk1($sformatf("reset busy u%0d", k), bsy[k], 1'b0);
    end
    rst = 1'b0;
    for (int k = 0; k < 4; k++) chk1($sformatf("post-reset ready u%0d", k), rdy[k], 1'b1);
    tick();

`ifndef UART_TX_FIFO_EN
    // 8N1, 0x35
    send(0, 8'h35);
    check_frame(0, 16'b000000_1_00110101_0, 100, 1'b1);
    check_idle(0, "8N1 end");
    tick();

    // 8E1 and 8O1, 0x35 has four ones
    send(1, 8'h35);
    check_frame(1, 16'b00000_10_00110101_0, 110, 1'b1);
    check_idle(1, "8E1 end");
    send(2, 8'h35);
    check_frame(2, 16'b00000_11_00110101_0, 110, 1'b1);
    check_idle(2, "8O1 end");

    // 7N2, 0x7F
    send(3, 8'h7F);
    check_frame(3, 16'b000000_11_1111111_0, 100, 1'b1);
    check_idle(3, "7N2 end");
    tick();

    // Back-to-back with tx_valid held: exactly one idle cycle between frames
    d0 = 8'hA5;
    vld[0] = 1'b1;
    chk1("b2b ready first", rdy[0], 1'b1);
    tick();
    d0 = 8'h5A;
    check_frame(0, 16'b000000_1_10100101_0, 100, 1'b1);
    check_idle(0, "b2b gap");
    tick();
    vld[0] = 1'b0;
    check_frame(0, 16'b000000_1_01011010_0, 100, 1'b1);
    check_idle(0, "b2b end");
    tick();

    // Reset in the middle of a frame, then a clean frame
    send(0, 8'h35);
    check_frame(0, 16'b000000_1_00110101_0, 45, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle(0, "mid-frame reset");
    tick();
    check_idle(0, "after reset idle");
    send(0, 8'hC3);
    check_frame(0, 16'b000000_1_11000011_0, 100, 1'b1);
    check_idle(0, "after reset frame end");
`else
    // Five consecutive pushes into a 4-deep FIFO while frames drain in order
    fork
      begin
        for (int w = 1; w <= 5; w++) begin
          d0 = w[7:0];
          vld[0] = 1'b1;
          chk1($sformatf("fifo push ready w%0d", w), rdy[0], 1'b1);
          tick();
        end
        vld[0] = 1'b0;
        chk1("fifo full ready", rdy[0], 1'b0);
      end
      begin
        int n;
        logic [15:0] f;
        for (int w = 1; w <= 5; w++) begin
          n = 0;
          while (txs[0] !== 1'b0 && n < 300) begin
            tick();
            n++;
          end
          chkn($sformatf("fifo start delay w%0d", w), n, (w == 1) ? 2 : 1);
          f = {6'b0, 1'b1, w[7:0], 1'b0};
          check_frame(0, f, 100, 1'b0);
        end
        check_idle(0, "fifo drained");
      end
    join
`endif

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
